branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the fixed resolve-in-decode scheme (equality compare in D, no prediction) with a table of 2-bit saturating counters.
- Indexing is selectable: bimodal (PC only) or gshare (PC XOR global history).
- Lookup happens in fetch. The prediction is carried to decode alongside instrD. Training happens when the branch resolves in M (branchM / branch_takeM path).

---
 rtl/branch_predictor_if.sv | 26 ++
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/decode/resolve signal bundle between the MIPS pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if;
    logic [31:0] pcF;
    logic        stallD;
    logic        flushD;
    logic        pred_takeF;
    logic        pred_takeD;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_take;
    logic        update_pred;
    logic        mispredict;

    modport master (
        output pcF, stallD, flushD,
        output update_en, update_pc, update_take, update_pred,
        input  pred_takeF, pred_takeD, mispredict
    );

    modport slave (
        input  pcF, stallD, flushD,
        input  update_en, update_pc, update_take, update_pred,
        output pred_takeF, pred_takeD, mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal/gshare predictor with a flop-based table of 2-bit saturating counters.
// Define BP_STATS_EN to build the saturating misprediction counter on mispredict_cnt.
module branch_predictor #(
    parameter int PHT_DEPTH = 256,
    parameter int IDX_LSB   = 2,
    parameter int MODE      = 1,
    parameter int GHR_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp,
    output logic [GHR_BITS-1:0] ghr,
    output logic [31:0]         mispredict_cnt
);
    localparam int W = $clog2(PHT_DEPTH);

    generate
        if (PHT_DEPTH < 4 || PHT_DEPTH > 4096 || (1 << W) != PHT_DEPTH)
            $error("branch_predictor: PHT_DEPTH must be a power of two in 4..4096");
        if (MODE != 0 && MODE != 1)
            $error("branch_predictor: MODE must be 0 or 1");
        if (GHR_BITS < 1 || GHR_BITS > W)
            $error("branch_predictor: GHR_BITS must be in 1..log2(PHT_DEPTH)");
        if (IDX_LSB < 0 || IDX_LSB + W > 32)
            $error("branch_predictor: IDX_LSB + log2(PHT_DEPTH) must fit in 32 bits");
    endgenerate

    logic [1:0]   pht [PHT_DEPTH];
    logic [W-1:0] hist;
    logic [W-1:0] idx_f;
    logic [W-1:0] idx_u;
    logic [1:0]   cnt_cur;
    logic [1:0]   cnt_next;
    logic         pred_d;

    // PC bits outside the index window are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pcF, bp.update_pc};

    assign hist  = (MODE != 0) ? W'(ghr) : '0;
    assign idx_f = bp.pcF[IDX_LSB +: W] ^ hist;
    assign idx_u = bp.update_pc[IDX_LSB +: W] ^ hist;

    // Lookup reads the stored table only; updates land on the edge, so no bypass.
    assign bp.pred_takeF = pht[idx_f][1];
    assign bp.mispredict = bp.update_en & (bp.update_take ^ bp.update_pred);

    assign cnt_cur = pht[idx_u];

    always_comb begin
        cnt_next = cnt_cur;
        if (bp.update_take) begin
            if (cnt_cur != 2'b11)
                cnt_next = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00)
                cnt_next = cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_DEPTH; i++)
                pht[i] <= 2'b01;
        end else if (bp.update_en) begin
            pht[idx_u] <= cnt_next;
        end
    end

    generate
        if (MODE != 0) begin : g_ghr
            // Truncating {ghr, take} keeps the youngest GHR_BITS outcomes for any GHR_BITS >= 1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ghr <= '0;
                else if (bp.update_en)
                    ghr <= GHR_BITS'({ghr, bp.update_take});
            end
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pred_d <= 1'b0;
        else if (bp.flushD)
            pred_d <= 1'b0;
        else if (!bp.stallD)
            pred_d <= bp.pred_takeF;
    end

    assign bp.pred_takeD = pred_d;

`ifdef BP_STATS_EN
    logic [31:0] stats_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stats_cnt <= '0;
        else if (bp.mispredict && stats_cnt != '1)
            stats_cnt <= stats_cnt + 32'd1;
    end

    assign mispredict_cnt = stats_cnt;
`else
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share directed stimulus and are
// compared every cycle against an array-based model, plus hand-computed spot values.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_take = 1'b0;
    logic        update_pred = 1'b0;
    logic        started = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ghr0, ghr1;
    logic [31:0] cnt0, cnt1;

    branch_predictor_if bus0 ();
    branch_predictor_if bus1 ();

    assign bus0.pcF = pcF;
    assign bus0.stallD = stallD;
    assign bus0.flushD = flushD;
    assign bus0.update_en = update_en;
    assign bus0.update_pc = update_pc;
    assign bus0.update_take = update_take;
    assign bus0.update_pred = update_pred;
    assign bus1.pcF = pcF;
    assign bus1.stallD = stallD;
    assign bus1.flushD = flushD;
    assign bus1.update_en = update_en;
    assign bus1.update_pc = update_pc;
    assign bus1.update_take = update_take;
    assign bus1.update_pred = update_pred;

    branch_predictor #(.PHT_DEPTH(256), .IDX_LSB(2), .MODE(0), .GHR_BITS(8)) dut0 (
        .clk(clk), .rst(rst), .bp(bus0), .ghr(ghr0), .mispredict_cnt(cnt0)
    );

    branch_predictor #(.PHT_DEPTH(256), .IDX_LSB(2), .MODE(1), .GHR_BITS(8)) dut1 (
        .clk(clk), .rst(rst), .bp(bus1), .ghr(ghr1), .mispredict_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // Model: counters as integers 0..3, history as an integer; index 0 is bimodal, 1 is gshare.
    int unsigned m_tab [2][256];
    int unsigned m_ghr [2];
    bit          m_pd  [2];
    longint unsigned m_cnt [2];

    function automatic int unsigned m_idx(input int m, input logic [31:0] pc);
        int unsigned base;
        base = (pc >> 2) % 256;
        if (m == 1)
            return base ^ (m_ghr[m] % 256);
        return base;
    endfunction

    function automatic bit m_pred(input int m, input logic [31:0] pc);
        return m_tab[m][m_idx(m, pc)] >= 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 256; i++) m_tab[m][i] = 1;
                m_ghr[m] = 0;
                m_pd[m]  = 0;
                m_cnt[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit pf;
                int unsigned ix;
                pf = m_pred(m, pcF);
                if (flushD) m_pd[m] = 0;
                else if (!stallD) m_pd[m] = pf;
                if (update_en) begin
                    ix = m_idx(m, update_pc);
                    if (update_take && m_tab[m][ix] < 3) m_tab[m][ix] = m_tab[m][ix] + 1;
                    if (!update_take && m_tab[m][ix] > 0) m_tab[m][ix] = m_tab[m][ix] - 1;
                    if (m == 1) m_ghr[m] = ((m_ghr[m] * 2) + (update_take ? 1 : 0)) % 256;
                    if (update_take != update_pred && m_cnt[m] < 64'hFFFF_FFFF)
                        m_cnt[m] = m_cnt[m] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int m);
`ifdef BP_STATS_EN
        return m_cnt[m][31:0];
`else
        return (m == 0) ? 32'h0 : 32'h0;
`endif
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("predF0", {31'b0, bus0.pred_takeF}, {31'b0, m_pred(0, pcF)});
            chk("predF1", {31'b0, bus1.pred_takeF}, {31'b0, m_pred(1, pcF)});
            chk("predD0", {31'b0, bus0.pred_takeD}, {31'b0, m_pd[0]});
            chk("predD1", {31'b0, bus1.pred_takeD}, {31'b0, m_pd[1]});
            chk("mispred0", {31'b0, bus0.mispredict}, {31'b0, update_en && (update_take != update_pred)});
            chk("mispred1", {31'b0, bus1.mispredict}, {31'b0, update_en && (update_take != update_pred)});
            chk("ghr0", {24'b0, ghr0}, m_ghr[0]);
            chk("ghr1", {24'b0, ghr1}, m_ghr[1]);
            chk("cnt0", cnt0, exp_cnt(0));
            chk("cnt1", cnt1, exp_cnt(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] pc, input logic take, input logic pred);
        update_en = 1'b1;
        update_pc = pc;
        update_take = take;
        update_pred = pred;
        step();
        update_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        // Reset sweep over 0x0..0x3FC
        for (int a = 0; a < 256; a++) begin
            pcF = 32'(a) << 2;
            @(negedge clk);
        end
        #1;
        chk("lit_reset_predF", {31'b0, bus0.pred_takeF}, 32'h0);
        chk("lit_reset_ghr1", {24'b0, ghr1}, 32'h0);
        chk("lit_reset_predD", {31'b0, bus1.pred_takeD}, 32'h0);

        // Bimodal training and saturation at 0xBFC0_0010
        step();
        pcF = 32'hBFC0_0010;
        update_en = 1'b1;
        update_pc = 32'hBFC0_0010;
        update_take = 1'b1;
        update_pred = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (k == 0) chk("lit_bimodal_first_pre", {31'b0, bus0.pred_takeF}, 32'h0);
            else        chk("lit_bimodal_after", {31'b0, bus0.pred_takeF}, 32'h1);
            step();
        end
        update_en = 1'b0;
        settle();
        chk("lit_bimodal_sat", {31'b0, bus0.pred_takeF}, 32'h1);
        pcF = 32'hBFC0_0014;
        #1;
        chk("lit_bimodal_other", {31'b0, bus0.pred_takeF}, 32'h0);
        pcF = 32'hBFC0_0010;
        pulse(32'hBFC0_0010, 1'b0, 1'b1);
        settle();
        chk("lit_bimodal_11to10", {31'b0, bus0.pred_takeF}, 32'h1);
        pulse(32'hBFC0_0010, 1'b0, 1'b1);
        settle();
        chk("lit_bimodal_10to01", {31'b0, bus0.pred_takeF}, 32'h0);

        // Gshare history 1,0,1,1 at pc 0x100 (base index 0x40)
        step();
        do_reset();
        pulse(32'h100, 1'b1, 1'b0);
        pulse(32'h100, 1'b0, 1'b0);
        pulse(32'h100, 1'b1, 1'b0);
        pulse(32'h100, 1'b1, 1'b0);
        settle();
        chk("lit_gshare_ghr", {24'b0, ghr1}, 32'h0000_000B);
        chk("lit_bimodal_ghr", {24'b0, ghr0}, 32'h0);
        pcF = 32'h12C; #1; chk("lit_gshare_e40", {31'b0, bus1.pred_takeF}, 32'h1);
        pcF = 32'h128; #1; chk("lit_gshare_e41", {31'b0, bus1.pred_takeF}, 32'h0);
        pcF = 32'h124; #1; chk("lit_gshare_e42", {31'b0, bus1.pred_takeF}, 32'h1);
        pcF = 32'h138; #1; chk("lit_gshare_e45", {31'b0, bus1.pred_takeF}, 32'h1);
        pcF = 32'h120; #1; chk("lit_gshare_e43", {31'b0, bus1.pred_takeF}, 32'h0);

        // Same-cycle lookup/update, then stall and flush of the decode register
        step();
        do_reset();
        pcF = 32'h200;
        update_en = 1'b1;
        update_pc = 32'h200;
        update_take = 1'b1;
        update_pred = 1'b0;
        settle();
        chk("lit_same_cycle_pre", {31'b0, bus0.pred_takeF}, 32'h0);
        chk("lit_same_cycle_mispred", {31'b0, bus0.mispredict}, 32'h1);
        step();
        update_en = 1'b0;
        settle();
        chk("lit_same_cycle_post", {31'b0, bus0.pred_takeF}, 32'h1);
        chk("lit_predD_old", {31'b0, bus0.pred_takeD}, 32'h0);
        step();
        chk("lit_predD_load", {31'b0, bus0.pred_takeD}, 32'h1);
        pcF = 32'h300;
        stallD = 1'b1;
        step();
        chk("lit_predD_stall", {31'b0, bus0.pred_takeD}, 32'h1);
        flushD = 1'b1;
        step();
        chk("lit_predD_flush", {31'b0, bus0.pred_takeD}, 32'h0);
        stallD = 1'b0;
        flushD = 1'b0;

        // Misprediction statistics and asynchronous mid-sequence reset
        step();
        do_reset();
        pcF = 32'h100;
        for (int k = 0; k < 5; k++) pulse(32'h100, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) pulse(32'h100, 1'b1, 1'b1);
        settle();
`ifdef BP_STATS_EN
        chk("lit_stats_cnt0", cnt0, 32'd5);
        chk("lit_stats_cnt1", cnt1, 32'd5);
`else
        chk("lit_stats_cnt0", cnt0, 32'd0);
        chk("lit_stats_cnt1", cnt1, 32'd0);
`endif
        chk("lit_stats_predF0", {31'b0, bus0.pred_takeF}, 32'h1);
        step();
        update_en = 1'b1;
        update_pc = 32'h100;
        update_take = 1'b0;
        update_pred = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("lit_async_ghr1", {24'b0, ghr1}, 32'h0);
        chk("lit_async_cnt0", cnt0, 32'h0);
        chk("lit_async_predF0", {31'b0, bus0.pred_takeF}, 32'h0);
        chk("lit_async_predD0", {31'b0, bus0.pred_takeD}, 32'h0);
        step();
        rst = 1'b0;
        update_en = 1'b0;
        settle();
        chk("lit_discard_predF0", {31'b0, bus0.pred_takeF}, 32'h0);
        chk("lit_discard_ghr1", {24'b0, ghr1}, 32'h0);

        repeat (2) step();
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
